// File: rtl/ddr_lane_judge.sv
// Note-scroll grid, hit judgement, score/miss bookkeeping and IDLE/PLAY/OVER control for the DDR game.
// Define DDR_COMBO_EN to enable the combo counter (+2 per hit once the combo reaches 4).
module ddr_lane_judge #(
    parameter int LANES     = 4,
    parameter int ROWS      = 8,
    parameter int SCORE_W   = 10,
    parameter int SCORE_MAX = 999,
    parameter int MAX_MISS  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            step,
    input  logic [LANES-1:0]                spawn,
    input  logic [LANES-1:0]                key,
    output logic [ROWS*LANES-1:0]           rows,
    output logic [SCORE_W-1:0]              score,
    output logic [$clog2(MAX_MISS+1)-1:0]   misses,
    output logic [LANES-1:0]                hit,
    output logic                            miss_p,
    output logic [1:0]                      state
);

    // state  | meaning
    // IDLE   | waiting for start, grid held empty
    // PLAY   | scrolling and judging presses
    // OVER   | miss limit reached, everything frozen until start

    localparam int MW  = $clog2(MAX_MISS+1);
    localparam int CW  = $clog2(LANES+1);
    localparam int GW  = ROWS*LANES;
    localparam int SSW = SCORE_W + CW + 2;
    localparam int MSW = MW + CW + 2;
    localparam logic [SSW-1:0] SCORE_LIM = SSW'(SCORE_MAX);
    localparam logic [MSW-1:0] MISS_LIM  = MSW'(MAX_MISS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       rows_q, rows_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [MW-1:0]       misses_q, misses_d;
    logic [LANES-1:0]    hit_q, hit_d;
    logic                miss_q, miss_d;
    logic [LANES-1:0]    key_q;

    logic [LANES-1:0]    press, hit_row, hits, pmiss, fall;
    logic [CW-1:0]       hit_cnt;
    logic [CW:0]         score_add;
    logic [SSW-1:0]      score_sum;
    logic [MSW-1:0]      miss_sum;

`ifdef DDR_COMBO_EN
    logic [3:0]          combo_q, combo_d;
    logic [CW+3:0]       combo_sum;
`endif

    function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    always_comb begin
        press     = key & ~key_q;
        hit_row   = rows_q[GW-1 -: LANES];
        hits      = press & hit_row;
        pmiss     = press & ~hit_row;
        // a note hit this cycle is already cleared, so it cannot also fall off
        fall      = step ? (hit_row & ~hits) : '0;
        hit_cnt   = popcount(hits);
        miss_sum  = MSW'(misses_q) + MSW'(popcount(pmiss)) + MSW'(popcount(fall));
`ifdef DDR_COMBO_EN
        score_add = (combo_q >= 4'd4) ? {hit_cnt, 1'b0} : {1'b0, hit_cnt};
        combo_sum = (CW+4)'(combo_q) + (CW+4)'(hit_cnt);
`else
        score_add = {1'b0, hit_cnt};
`endif
        score_sum = SSW'(score_q) + SSW'(score_add);

        state_d  = state_q;
        rows_d   = rows_q;
        score_d  = score_q;
        misses_d = misses_q;
        hit_d    = '0;
        miss_d   = 1'b0;
`ifdef DDR_COMBO_EN
        combo_d  = combo_q;
`endif

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (state_q == ST_IDLE) rows_d = '0;
                if (start) begin
                    state_d  = ST_PLAY;
                    rows_d   = '0;
                    score_d  = '0;
                    misses_d = '0;
`ifdef DDR_COMBO_EN
                    combo_d  = '0;
`endif
                end
            end
            ST_PLAY: begin
                if (step) rows_d = {rows_q[GW-LANES-1:0], spawn};
                else      rows_d = {hit_row & ~hits, rows_q[GW-LANES-1:0]};
                score_d  = (score_sum >= SCORE_LIM) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];
                misses_d = (miss_sum >= MISS_LIM) ? MW'(MAX_MISS) : miss_sum[MW-1:0];
                hit_d    = hits;
                miss_d   = (pmiss | fall) != '0;
`ifdef DDR_COMBO_EN
                if (miss_d)                        combo_d = '0;
                else if (combo_sum >= (CW+4)'(15)) combo_d = 4'd15;
                else                               combo_d = combo_sum[3:0];
`endif
                if (miss_sum >= MISS_LIM) state_d = ST_OVER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rows_q   <= '0;
            score_q  <= '0;
            misses_q <= '0;
            hit_q    <= '0;
            miss_q   <= 1'b0;
            key_q    <= '1;
`ifdef DDR_COMBO_EN
            combo_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rows_q   <= rows_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            key_q    <= key;
`ifdef DDR_COMBO_EN
            combo_q  <= combo_d;
`endif
        end
    end

    assign rows   = rows_q;
    assign score  = score_q;
    assign misses = misses_q;
    assign hit    = hit_q;
    assign miss_p = miss_q;
    assign state  = state_q;

endmodule

// File: tb/tb_ddr_lane_judge.sv
// Scoreboard bench for ddr_lane_judge: stimulus queues expected snapshots and pulses, a monitor compares.
// A second instance with SCORE_MAX=3 shares all inputs and checks score saturation.
module tb_ddr_lane_judge;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] PLAY = 2'b01;
    localparam logic [1:0] OVER = 2'b10;
`ifdef DDR_COMBO_EN
    localparam int FIVE_HIT_SCORE = 6;
`else
    localparam int FIVE_HIT_SCORE = 5;
`endif

    logic        clk = 1'b0;
    logic        reset, start, step;
    logic [3:0]  spawn, key;
    logic [31:0] rows, rows_s;
    logic [9:0]  score, score_s;
    logic [3:0]  misses, misses_s;
    logic [3:0]  hit, hit_s;
    logic        miss_p, miss_p_s;
    logic [1:0]  state, state_s;

    always #5 clk = ~clk;

    ddr_lane_judge u_dut (
        .clk(clk), .reset(reset), .start(start), .step(step), .spawn(spawn), .key(key),
        .rows(rows), .score(score), .misses(misses), .hit(hit), .miss_p(miss_p), .state(state)
    );

    ddr_lane_judge #(.SCORE_MAX(3)) u_sat (
        .clk(clk), .reset(reset), .start(start), .step(step), .spawn(spawn), .key(key),
        .rows(rows_s), .score(score_s), .misses(misses_s), .hit(hit_s), .miss_p(miss_p_s), .state(state_s)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] rows;
        int          score;
        int          misses;
        logic [1:0]  state;
    } snap_t;

    typedef struct {
        string      name;
        logic [3:0] hit;
        logic       miss_p;
    } pulse_t;

    snap_t  snap_q[$];
    pulse_t pulse_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    logic   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(input logic [3:0] sp);
        step = 1'b1;
        spawn = sp;
        cycle();
        step = 1'b0;
        spawn = '0;
    endtask

    task automatic expect_snap(input string n, input logic [31:0] r, input int sc, input int ms, input logic [1:0] st);
        snap_t s;
        s.name = n; s.cyc = cyc; s.rows = r; s.score = sc; s.misses = ms; s.state = st;
        snap_q.push_back(s);
    endtask

    task automatic expect_pulse(input string n, input logic [3:0] h, input logic m);
        pulse_t p;
        p.name = n; p.hit = h; p.miss_p = m;
        pulse_q.push_back(p);
    endtask

    always @(negedge clk) begin : monitor
        snap_t  s;
        pulse_t p;
        int     sat_exp;
        while (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
            s = snap_q.pop_front();
            checks++;
            if (rows !== s.rows || score !== 10'(s.score) || misses !== 4'(s.misses) || state !== s.state) begin
                errors++;
                $display("FAIL %s: got rows=%h score=%0d misses=%0d state=%b, want rows=%h score=%0d misses=%0d state=%b",
                         s.name, rows, score, misses, state, s.rows, s.score, s.misses, s.state);
            end
            sat_exp = (s.score > 3) ? 3 : s.score;
            checks++;
            if (score_s !== 10'(sat_exp)) begin
                errors++;
                $display("FAIL %s_sat: got score=%0d want %0d", s.name, score_s, sat_exp);
            end
        end
        if (hit !== 4'b0000 || miss_p !== 1'b0) begin
            checks++;
            if (pulse_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got hit=%b miss_p=%b want none (cycle %0d)", hit, miss_p, cyc);
            end else begin
                p = pulse_q.pop_front();
                if (hit !== p.hit || miss_p !== p.miss_p) begin
                    errors++;
                    $display("FAIL %s: got hit=%b miss_p=%b want hit=%b miss_p=%b", p.name, hit, miss_p, p.hit, p.miss_p);
                end
            end
        end
        if (done) begin
            checks++;
            if (snap_q.size() != 0) begin
                errors++;
                $display("FAIL snap_drain: got %0d unchecked want 0", snap_q.size());
            end
            checks++;
            if (pulse_q.size() != 0) begin
                errors++;
                $display("FAIL pulse_drain: got %0d missing pulses want 0 (first %s)", pulse_q.size(), pulse_q[0].name);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; step = 1'b0; spawn = '0; key = '0;
        cycle(); cycle();
        expect_snap("reset", 32'h0, 0, 0, IDLE);
        reset = 1'b0;
        cycle();

        do_step(4'hF);
        expect_snap("idle_step", 32'h0, 0, 0, IDLE);
        key = 4'b0001; cycle(); key = '0; cycle();
        expect_snap("idle_key", 32'h0, 0, 0, IDLE);
        start = 1'b1; cycle(); start = 1'b0;
        expect_snap("start", 32'h0, 0, 0, PLAY);

        do_step(4'b0001);
        expect_snap("spawn_row0", 32'h0000_0001, 0, 0, PLAY);
        repeat (7) do_step(4'b0000);
        expect_snap("reach_hit_row", 32'h1000_0000, 0, 0, PLAY);
        key = 4'b0001; cycle();
        expect_pulse("hit_lane0", 4'b0001, 1'b0);
        expect_snap("hit_lane0", 32'h0, 1, 0, PLAY);
        cycle();
        expect_snap("hold_no_rehit", 32'h0, 1, 0, PLAY);
        key = '0; cycle();

        do_step(4'b0001);
        repeat (7) do_step(4'b0000);
        expect_snap("pre_falloff", 32'h1000_0000, 1, 0, PLAY);
        do_step(4'b0000);
        expect_pulse("falloff", 4'b0000, 1'b1);
        expect_snap("falloff", 32'h0, 1, 1, PLAY);

        key = 4'b0100; cycle();
        expect_pulse("press_miss", 4'b0000, 1'b1);
        expect_snap("press_miss", 32'h0, 1, 2, PLAY);
        repeat (4) cycle();
        expect_snap("held_key", 32'h0, 1, 2, PLAY);
        key = '0; cycle();
        key = 4'b0100; cycle();
        expect_pulse("repress", 4'b0000, 1'b1);
        expect_snap("repress", 32'h0, 1, 3, PLAY);
        key = '0; cycle();

        do_step(4'b0011);
        repeat (7) do_step(4'b0000);
        expect_snap("two_notes", 32'h3000_0000, 1, 3, PLAY);
        key = 4'b0001; step = 1'b1; cycle(); step = 1'b0;
        expect_pulse("hit_and_step", 4'b0001, 1'b1);
        expect_snap("hit_and_step", 32'h0, 2, 4, PLAY);
        key = '0; cycle();

        key = 4'b0001; cycle();
        expect_pulse("miss_five", 4'b0000, 1'b1);
        expect_snap("miss_five", 32'h0, 2, 5, PLAY);
        key = '0; cycle();
        key = 4'b1111; cycle();
        expect_pulse("miss_sat", 4'b0000, 1'b1);
        expect_snap("miss_sat_over", 32'h0, 2, 8, OVER);
        key = '0;
        do_step(4'hF);
        key = 4'b0010; cycle();
        expect_snap("over_frozen", 32'h0, 2, 8, OVER);
        key = '0; cycle();
        start = 1'b1; cycle(); start = 1'b0;
        expect_snap("restart", 32'h0, 0, 0, PLAY);

        for (int i = 0; i < 8; i++) do_step((i < 5) ? 4'b0001 : 4'b0000);
        expect_snap("five_queued", 32'h1111_1000, 0, 0, PLAY);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) do_step(4'b0000);
            key = 4'b0001; cycle();
            expect_pulse("combo_hit", 4'b0001, 1'b0);
            key = '0; cycle();
        end
        expect_snap("five_hits", 32'h0, FIVE_HIT_SCORE, 0, PLAY);

        key = 4'b0100; cycle();
        expect_pulse("pm_a", 4'b0000, 1'b1);
        key = '0; cycle();
        key = 4'b0100; cycle();
        expect_pulse("pm_b", 4'b0000, 1'b1);
        expect_snap("two_misses", 32'h0, FIVE_HIT_SCORE, 2, PLAY);
        key = '0; cycle();
        do_step(4'b1010);
        expect_snap("grid_loaded", 32'h0000_000A, FIVE_HIT_SCORE, 2, PLAY);
        cycle();
        reset = 1'b1;
        expect_snap("reset_mid", 32'h0, 0, 0, IDLE);
        cycle();
        reset = 1'b0;
        cycle();
        expect_snap("after_reset", 32'h0, 0, 0, IDLE);
        start = 1'b1; cycle(); start = 1'b0;
        expect_snap("start_after_reset", 32'h0, 0, 0, PLAY);
        cycle();

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_lane_judge.md
# ddr_lane_judge

Parametrised note-scroll and hit-judgement engine for the DDR game. It holds a LANES-wide by ROWS-deep note grid that scrolls one row per `step` pulse, and judges edge-detected key presses against the bottom (hit) row. It keeps a saturating score and a miss count, and runs the IDLE/PLAY/OVER game state machine. It sits between the input synchronizers and the LED-matrix and HEX display drivers in the DDR top level.

## Interface
Parameters:
- LANES, 4, number of note lanes and keys
- ROWS, 8, grid depth; row ROWS-1 is the hit row
- SCORE_W, 10, score width
- SCORE_MAX, 999, score saturation value (must fit SCORE_W)
- MAX_MISS, 8, miss count that ends the game

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- start  in  1  level; begins a game from IDLE or OVER
- step  in  1  one-cycle scroll tick
- spawn  in  LANES  notes entering row 0, sampled only on `step`
- key  in  LANES  synchronized, active-high pressed (top level inverts KEY)
- rows  out  ROWS*LANES  note map; bit r*LANES+l = row r, lane l
- score  out  SCORE_W  current score
- misses  out  $clog2(MAX_MISS+1)  current miss count
- hit  out  LANES  one-cycle pulse per lane judged a hit
- miss_p  out  1  one-cycle pulse when misses increments
- state  out  2  00 IDLE, 01 PLAY, 10 OVER

## Operation
- Reset values: rows 0, score 0, misses 0, hit 0, miss_p 0, state IDLE, internal key_q all ones. Because key_q resets to all ones, a key held through reset produces no press.
- A press is defined as press[l] = key[l] & ~key_q[l]. key_q <= key every cycle in every state.
- IDLE: grid held at 0; step, spawn and key are ignored. start -> PLAY, with score, misses and grid cleared.
- PLAY, evaluated each cycle in this order:
  1. Judge presses against the current hit row. press & note -> hit: clear the note and add 1 to score. press & no note -> press-miss.
  2. If step: the grid shifts down one row and row 0 <= spawn. Notes still set in the hit row after step 1 fall off and each counts as one miss.
  - A note hit in the same cycle as a step is never counted as a fall-off miss.
  - misses += popcount(press-misses) + popcount(fall-offs), saturating at MAX_MISS.
  - score saturates at SCORE_MAX.
  - If the updated misses >= MAX_MISS, state -> OVER on the same edge.
- OVER: grid, score and misses frozen; step and key are ignored. start -> PLAY with the same clears as from IDLE.
- A step in IDLE or OVER changes nothing.

## Timing
- All outputs are registered.
- A press first sampled at edge k updates rows, score, misses, hit, miss_p and state at edge k. The updates are visible in the cycle after edge k.
- hit and miss_p are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- A held key yields exactly one press. Re-pressing requires key low for at least one cycle.
- Scroll latency: a note spawned on a step reaches the hit row after ROWS-1 further steps, and falls off on the ROWS-th further step.
- Reset asserted mid-game forces reset values asynchronously. The first edge after deassertion sees state IDLE.

## Configuration
- DDR_COMBO_EN defined: adds an internal combo counter, saturating at 15.
  - Each hit increments the combo; any miss clears it to 0.
  - A hit scores +2 if the combo before the hit is >= 4, otherwise +1.
  - Multiple simultaneous hits are scored with the pre-cycle combo.
  - The counter resets to 0 on reset and on start.
- DDR_COMBO_EN undefined: no combo counter; every hit scores +1.

## Test plan
- Reset mid-play: in PLAY with score 5, misses 2 and a non-zero grid, pulse reset -> rows 0, score 0, misses 0, state 00, hit 0, all immediately.
- Scroll and hit: start, then step with spawn=0001, then 7 more steps -> rows bit 28 set. Raise key[0] -> hit=0001 for one cycle, score 1, bit 28 cleared, misses 0.
- Fall-off: spawn a lane-0 note and step 8 times with no press -> misses 1, one-cycle miss_p on the 8th step, rows 0.
- Press-miss and hold: raise key[2] with an empty hit row and hold it 5 cycles -> misses +1 exactly once. Release for 1 cycle and press again -> misses +1.
- Simultaneous press and step: lanes 0 and 1 in the hit row; press key[0] in the same cycle as step -> score +1, misses +1, hit=0001, both notes leave the hit row.
- Saturation and OVER:
  - 8 misses -> state 10; further steps and presses leave rows, score and misses unchanged; start -> state 01, score 0, misses 0.
  - With SCORE_MAX=3, 5 hits -> score 3.
  - With DDR_COMBO_EN, 5 consecutive hits -> score 6; without it -> score 5.
